// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: one valid/ready channel carrying ctrl, data words and a register number
interface pipe_skid_reg_if #(
  parameter int DW    = 32,
  parameter int NDATA = 2,
  parameter int RW    = 5,
  parameter int CW    = 3
);
  logic                valid;
  logic                ready;
  logic [CW-1:0]       ctrl;
  logic [NDATA*DW-1:0] data;
  logic [RW-1:0]       rn;
  modport master (output valid, ctrl, data, rn, input ready);
  modport slave  (input valid, ctrl, data, rn, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with 2-entry skid buffer, flush and bubble gating
module pipe_skid_reg #(
  parameter int DW    = 32,
  parameter int NDATA = 2,
  parameter int RW    = 5,
  parameter int CW    = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  pipe_skid_reg_if.slave    up,
  pipe_skid_reg_if.master   down,
  output logic [1:0]        level
);
  localparam int PW = CW + NDATA * DW + RW;
  logic          main_v, skid_v, rdy;
  logic [PW-1:0] main_q, skid_q, in_beat;
  logic          accept, pop, take;
  assign in_beat = {up.ctrl, up.data, up.rn};
  assign accept  = up.valid & rdy;
  assign pop     = main_v & down.ready;
  // main slot is free for a new occupant this cycle (empty or being popped)
  assign take    = !main_v | pop;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy    <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy    <= 1'b1;
    end else begin
      if (take) begin
        main_v <= skid_v | accept;
        if (skid_v | accept) main_q <= skid_v ? skid_q : in_beat;
        skid_v <= 1'b0;
      end else if (accept) begin
        skid_v <= 1'b1;
        skid_q <= in_beat;
      end
      rdy <= take | !(skid_v | accept);
    end
  assign up.ready   = rdy;
  assign down.valid = main_v;
  assign down.ctrl  = main_q[PW-1 -: CW] & {CW{main_v}};
  assign down.data  = main_q[RW +: NDATA*DW];
  assign down.rn    = main_q[RW-1:0];
  assign level      = 2'(main_v) + 2'(skid_v);
endmodule
